// File: rtl/physics_pkg.sv
// Shared definitions for the node integrator: controller states and the
// saturating-add width rule used by every velocity/position update.
package physics_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FULL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // One guard bit above the destination width is enough to hold any sum of
  // two in-range operands without wrapping, so clamping stays exact.
  localparam int SUM_GUARD_BITS = 1;

  function automatic int sum_width(input int width);
    return width + SUM_GUARD_BITS;
  endfunction

  function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] value,
                                                   input int width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/axis_integrate.sv
// Combinational single-axis step: v' = sat(v + (f >>> dt)), p' = sat(p + (v' >>> dt)).
module axis_integrate
  import physics_pkg::*;
#(
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int CONSTANT_SIZE = 4
) (
  input  logic        [CONSTANT_SIZE-1:0] dt_shift,
  input  logic signed [FORCE_SIZE-1:0]    force_val,
  input  logic signed [VELOCITY_SIZE-1:0] vel,
  input  logic signed [POSITION_SIZE-1:0] pos,
  output logic signed [VELOCITY_SIZE-1:0] vel_next,
  output logic signed [POSITION_SIZE-1:0] pos_next
);

  localparam int VSUM_W = sum_width(VELOCITY_SIZE);
  localparam int PSUM_W = sum_width(POSITION_SIZE);

  logic signed [FORCE_SIZE-1:0]    force_step;
  logic signed [VELOCITY_SIZE-1:0] vel_step;
  logic signed [VSUM_W-1:0]        vel_sum;
  logic signed [PSUM_W-1:0]        pos_sum;

  assign force_step = force_val >>> dt_shift;
  assign vel_sum    = VSUM_W'(vel) + VSUM_W'(force_step);
  assign vel_next   = VELOCITY_SIZE'(sat_clamp(32'(vel_sum), VELOCITY_SIZE));

  // Position integrates the freshly updated velocity (semi-implicit Euler).
  assign vel_step   = vel_next >>> dt_shift;
  assign pos_sum    = PSUM_W'(pos) + PSUM_W'(vel_step);
  assign pos_next   = POSITION_SIZE'(sat_clamp(32'(pos_sum), POSITION_SIZE));

endmodule

// File: rtl/node_integrator.sv
// Frame-based node integrator: force beats update shadow state per node and a
// complete frame is committed atomically to the outputs.
module node_integrator
  import physics_pkg::*;
#(
  parameter int NUM_NODES     = 10,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int CONSTANT_SIZE = 4
) (
  input  logic                                                 clk_in,
  input  logic                                                 rst_in,
  input  logic                                                 init_valid,
  input  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  init_nodes,
  input  logic        [CONSTANT_SIZE-1:0]                      dt_shift,
  input  logic signed [FORCE_SIZE-1:0]                         force_x_in,
  input  logic signed [FORCE_SIZE-1:0]                         force_y_in,
  input  logic                                                 force_in_valid,
  input  logic                                                 frame_done_in,
  output logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes_out,
  output logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  velocities_out,
  output logic                                                 update_valid,
  output logic                                                 count_error
);

  localparam int CNT_W = $clog2(NUM_NODES) + 1;
  localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(NUM_NODES);

  state_t                                              state_reg;
  logic [CNT_W-1:0]                                    count_reg;
  logic [CONSTANT_SIZE-1:0]                            dt_reg;
  logic signed [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] pos_shadow;
  logic signed [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_shadow;

  logic                         accept;
  logic [CNT_W-1:0]             count_base;
  logic [CNT_W-1:0]             count_after;
  logic [IDX_W-1:0]             beat_idx;
  logic [CONSTANT_SIZE-1:0]     dt_eff;
  logic signed [FORCE_SIZE-1:0]    force_sel [2];
  logic signed [VELOCITY_SIZE-1:0] vel_new   [2];
  logic signed [POSITION_SIZE-1:0] pos_new   [2];

  // The first beat of a frame arrives in IDLE, so it uses the live dt_shift.
  always_comb begin
    accept      = force_in_valid && (state_reg == IDLE || state_reg == ACCUM);
    count_base  = (state_reg == IDLE) ? '0 : count_reg;
    count_after = count_base + CNT_W'(accept);
    beat_idx    = count_base[IDX_W-1:0];
    dt_eff      = (state_reg == IDLE) ? dt_shift : dt_reg;
    force_sel[0] = force_x_in;
    force_sel[1] = force_y_in;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      axis_integrate #(
        .POSITION_SIZE(POSITION_SIZE),
        .VELOCITY_SIZE(VELOCITY_SIZE),
        .FORCE_SIZE   (FORCE_SIZE),
        .CONSTANT_SIZE(CONSTANT_SIZE)
      ) u_axis (
        .dt_shift (dt_eff),
        .force_val(force_sel[gi]),
        .vel      (vel_shadow[gi][beat_idx]),
        .pos      (pos_shadow[gi][beat_idx]),
        .vel_next (vel_new[gi]),
        .pos_next (pos_new[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      dt_reg         <= '0;
      pos_shadow     <= '0;
      vel_shadow     <= '0;
      nodes_out      <= '0;
      velocities_out <= '0;
      update_valid   <= 1'b0;
      count_error    <= 1'b0;
    end else begin
      update_valid <= 1'b0;
      count_error  <= 1'b0;
      case (state_reg)
        IDLE, ACCUM: begin
          if (accept) begin
            for (int a = 0; a < 2; a++) begin
              vel_shadow[a][beat_idx] <= vel_new[a];
              pos_shadow[a][beat_idx] <= pos_new[a];
            end
            count_reg <= count_after;
            if (state_reg == IDLE) dt_reg <= dt_shift;
          end else if (state_reg == IDLE && init_valid) begin
            nodes_out      <= init_nodes;
            pos_shadow     <= init_nodes;
            velocities_out <= '0;
            vel_shadow     <= '0;
          end
          // frame_done_in is judged against the count including a same-cycle beat.
          if (accept || state_reg == ACCUM) begin
            if (count_after == FRAME_LEN) begin
              state_reg <= frame_done_in ? COMMIT : FULL;
            end else if (frame_done_in) begin
              pos_shadow  <= nodes_out;
              vel_shadow  <= velocities_out;
              count_reg   <= '0;
              count_error <= 1'b1;
              state_reg   <= IDLE;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        FULL: begin
          count_error <= force_in_valid;
          if (frame_done_in) state_reg <= COMMIT;
        end
        COMMIT: begin
          nodes_out      <= pos_shadow;
          velocities_out <= vel_shadow;
          update_valid   <= 1'b1;
          count_reg      <= '0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_node_integrator.sv
// Directed self-checking bench for node_integrator with hand-computed vectors.
module tb_node_integrator;

  localparam int N = 10;

  logic                     clk_in = 1'b0;
  logic                     rst_in = 1'b0;
  logic                     init_valid = 1'b0;
  logic [1:0][N-1:0][7:0]   init_nodes = '0;
  logic [3:0]               dt_shift = '0;
  logic signed [7:0]        force_x_in = '0;
  logic signed [7:0]        force_y_in = '0;
  logic                     force_in_valid = 1'b0;
  logic                     frame_done_in = 1'b0;
  logic [1:0][N-1:0][7:0]   nodes_out;
  logic [1:0][N-1:0][7:0]   velocities_out;
  logic                     update_valid;
  logic                     count_error;

  int checks = 0;
  int errors = 0;
  int uv_count = 0;
  int ce_count = 0;
  bit both_seen = 1'b0;
  int fx_vec [12];
  int fy_vec [12];

  always #5 clk_in = ~clk_in;

  node_integrator #(
    .NUM_NODES(N), .POSITION_SIZE(8), .VELOCITY_SIZE(8),
    .FORCE_SIZE(8), .CONSTANT_SIZE(4)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .init_valid    (init_valid),
    .init_nodes    (init_nodes),
    .dt_shift      (dt_shift),
    .force_x_in    (force_x_in),
    .force_y_in    (force_y_in),
    .force_in_valid(force_in_valid),
    .frame_done_in (frame_done_in),
    .nodes_out     (nodes_out),
    .velocities_out(velocities_out),
    .update_valid  (update_valid),
    .count_error   (count_error)
  );

  always @(negedge clk_in) begin
    if (update_valid) uv_count++;
    if (count_error) ce_count++;
    if (update_valid && count_error) both_seen = 1'b1;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_beats(input int n, input int dt, input bit done_on_last);
    for (int k = 0; k < n; k++) begin
      force_in_valid = 1'b1;
      force_x_in     = 8'(fx_vec[k]);
      force_y_in     = 8'(fy_vec[k]);
      dt_shift       = 4'(dt);
      frame_done_in  = done_on_last && (k == n - 1);
      step();
    end
    force_in_valid = 1'b0;
    frame_done_in  = 1'b0;
    force_x_in     = '0;
    force_y_in     = '0;
  endtask

  task automatic pulse_done();
    frame_done_in = 1'b1;
    step();
    frame_done_in = 1'b0;
  endtask

  task automatic run_full(input int dt);
    drive_beats(N, dt, 1'b0);
    pulse_done();
    step();
    step();
  endtask

  task automatic load_init(input logic [1:0][N-1:0][7:0] pattern);
    init_nodes = pattern;
    init_valid = 1'b1;
    step();
    init_valid = 1'b0;
  endtask

  task automatic set_forces(input int x, input int y);
    for (int k = 0; k < 12; k++) begin
      fx_vec[k] = x;
      fy_vec[k] = y;
    end
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (nodes_out !== '0) begin errors++; $display("FAIL reset_nodes: got %h expected 0", nodes_out); end
    checks++;
    if (velocities_out !== '0) begin errors++; $display("FAIL reset_vel: got %h expected 0", velocities_out); end
    checks++;
    if (update_valid !== 1'b0) begin errors++; $display("FAIL reset_uv: got %b expected 0", update_valid); end
    checks++;
    if (count_error !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b expected 0", count_error); end
    rst_in = 1'b1;
    step();
    $display("reset: done");
  endtask

  task automatic test_init();
    logic [1:0][N-1:0][7:0] pat;
    logic signed [7:0] got, exp;
    uv_count = 0;
    for (int k = 0; k < N; k++) begin
      pat[0][k] = 8'(3 * k);
      pat[1][k] = 8'(-k);
    end
    load_init(pat);
    for (int k = 0; k < N; k++) begin
      got = nodes_out[0][k]; exp = 8'(3 * k);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL init_px[%0d]: got %0d expected %0d", k, got, exp); end
      got = nodes_out[1][k]; exp = 8'(-k);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL init_py[%0d]: got %0d expected %0d", k, got, exp); end
    end
    checks++;
    if (velocities_out !== '0) begin errors++; $display("FAIL init_vel: got %h expected 0", velocities_out); end
    step();
    checks++;
    if (uv_count !== 0) begin errors++; $display("FAIL init_no_uv: got %0d expected 0", uv_count); end
    $display("init: loaded pattern");
  endtask

  task automatic test_basic();
    logic signed [7:0] got, exp;
    uv_count = 0;
    load_init('0);
    for (int k = 0; k < 12; k++) begin
      fx_vec[k] = k + 1;
      fy_vec[k] = -1;
    end
    drive_beats(N, 0, 1'b0);
    checks++;
    if (nodes_out !== '0) begin errors++; $display("FAIL basic_hold: got %h expected 0", nodes_out); end
    pulse_done();
    checks++;
    if (update_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1: got %b expected 0", update_valid); end
    step();
    checks++;
    if (update_valid !== 1'b1) begin errors++; $display("FAIL basic_lat2: got %b expected 1", update_valid); end
    for (int k = 0; k < N; k++) begin
      got = velocities_out[0][k]; exp = 8'(k + 1);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL basic_vx[%0d]: got %0d expected %0d", k, got, exp); end
      got = velocities_out[1][k]; exp = -8'sd1;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL basic_vy[%0d]: got %0d expected %0d", k, got, exp); end
      got = nodes_out[0][k]; exp = 8'(k + 1);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL basic_px[%0d]: got %0d expected %0d", k, got, exp); end
      got = nodes_out[1][k]; exp = -8'sd1;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL basic_py[%0d]: got %0d expected %0d", k, got, exp); end
    end
    step();
    checks++;
    if (uv_count !== 1) begin errors++; $display("FAIL basic_uv_count: got %0d expected 1", uv_count); end
    $display("basic: frame committed");
  endtask

  task automatic test_saturation();
    logic signed [7:0] got;
    load_init('0);
    set_forces(0, 0); fx_vec[0] = 120; fy_vec[1] = -128;
    run_full(0);
    got = velocities_out[0][0];
    checks++;
    if (got !== 8'sd120) begin errors++; $display("FAIL sat_pre_vx0: got %0d expected 120", got); end
    set_forces(0, 0); fx_vec[0] = 20; fy_vec[1] = -128;
    run_full(0);
    got = velocities_out[0][0];
    checks++;
    if (got !== 8'sd127) begin errors++; $display("FAIL sat_vx0: got %0d expected 127", got); end
    got = nodes_out[0][0];
    checks++;
    if (got !== 8'sd127) begin errors++; $display("FAIL sat_px0: got %0d expected 127", got); end
    got = velocities_out[1][1];
    checks++;
    if (got !== -8'sd128) begin errors++; $display("FAIL sat_vy1: got %0d expected -128", got); end
    got = nodes_out[1][1];
    checks++;
    if (got !== -8'sd128) begin errors++; $display("FAIL sat_py1: got %0d expected -128", got); end
    set_forces(0, 0);
    run_full(0);
    got = nodes_out[0][0];
    checks++;
    if (got !== 8'sd127) begin errors++; $display("FAIL sat_hold_px0: got %0d expected 127", got); end
    got = nodes_out[0][2];
    checks++;
    if (got !== 8'sd0) begin errors++; $display("FAIL sat_px2: got %0d expected 0", got); end
    $display("saturation: clamped frames committed");
  endtask

  task automatic test_arith_shift();
    logic signed [7:0] got;
    load_init('0);
    set_forces(-7, 7);
    run_full(2);
    for (int k = 0; k < N; k += N - 1) begin
      got = velocities_out[0][k];
      checks++;
      if (got !== -8'sd2) begin errors++; $display("FAIL shift_vx[%0d]: got %0d expected -2", k, got); end
      got = nodes_out[0][k];
      checks++;
      if (got !== -8'sd1) begin errors++; $display("FAIL shift_px[%0d]: got %0d expected -1", k, got); end
      got = velocities_out[1][k];
      checks++;
      if (got !== 8'sd1) begin errors++; $display("FAIL shift_vy[%0d]: got %0d expected 1", k, got); end
      got = nodes_out[1][k];
      checks++;
      if (got !== 8'sd0) begin errors++; $display("FAIL shift_py[%0d]: got %0d expected 0", k, got); end
    end
    $display("arith_shift: dt_shift=2 frame committed");
  endtask

  task automatic test_short_frame();
    logic signed [7:0] got;
    uv_count = 0; ce_count = 0;
    set_forces(100, 100);
    drive_beats(5, 0, 1'b0);
    pulse_done();
    step();
    step();
    checks++;
    if (ce_count !== 1) begin errors++; $display("FAIL short_ce: got %0d expected 1", ce_count); end
    checks++;
    if (uv_count !== 0) begin errors++; $display("FAIL short_uv: got %0d expected 0", uv_count); end
    got = nodes_out[0][0];
    checks++;
    if (got !== -8'sd1) begin errors++; $display("FAIL short_px0: got %0d expected -1", got); end
    got = velocities_out[0][4];
    checks++;
    if (got !== -8'sd2) begin errors++; $display("FAIL short_vx4: got %0d expected -2", got); end
    set_forces(3, 0);
    run_full(0);
    for (int k = 0; k < 5; k += 4) begin
      got = velocities_out[0][k];
      checks++;
      if (got !== 8'sd1) begin errors++; $display("FAIL short_next_vx[%0d]: got %0d expected 1", k, got); end
      got = nodes_out[0][k];
      checks++;
      if (got !== 8'sd0) begin errors++; $display("FAIL short_next_px[%0d]: got %0d expected 0", k, got); end
      got = nodes_out[1][k];
      checks++;
      if (got !== 8'sd1) begin errors++; $display("FAIL short_next_py[%0d]: got %0d expected 1", k, got); end
    end
    checks++;
    if (uv_count !== 1) begin errors++; $display("FAIL short_next_uv: got %0d expected 1", uv_count); end
    $display("short_frame: discarded then recovered");
  endtask

  task automatic test_overrun();
    logic signed [7:0] got, exp;
    load_init('0);
    uv_count = 0; ce_count = 0;
    set_forces(0, 0);
    for (int k = 0; k < N; k++) fx_vec[k] = k + 1;
    fx_vec[10] = 50; fx_vec[11] = 50;
    drive_beats(12, 0, 1'b0);
    pulse_done();
    step();
    step();
    checks++;
    if (ce_count !== 2) begin errors++; $display("FAIL overrun_ce: got %0d expected 2", ce_count); end
    checks++;
    if (uv_count !== 1) begin errors++; $display("FAIL overrun_uv: got %0d expected 1", uv_count); end
    for (int k = 0; k < N; k++) begin
      got = nodes_out[0][k]; exp = 8'(k + 1);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL overrun_px[%0d]: got %0d expected %0d", k, got, exp); end
    end
    $display("overrun: two drops, first ten committed");
  endtask

  task automatic test_reset_mid();
    logic signed [7:0] got;
    uv_count = 0;
    set_forces(5, 5);
    drive_beats(3, 0, 1'b0);
    rst_in = 1'b0;
    #2;
    checks++;
    if (nodes_out !== '0) begin errors++; $display("FAIL rstmid_nodes: got %h expected 0", nodes_out); end
    checks++;
    if (velocities_out !== '0) begin errors++; $display("FAIL rstmid_vel: got %h expected 0", velocities_out); end
    checks++;
    if (update_valid !== 1'b0) begin errors++; $display("FAIL rstmid_uv: got %b expected 0", update_valid); end
    step();
    rst_in = 1'b1;
    step();
    pulse_done();
    step();
    step();
    checks++;
    if (uv_count !== 0) begin errors++; $display("FAIL rstmid_no_uv: got %0d expected 0", uv_count); end
    set_forces(2, 1);
    run_full(0);
    got = velocities_out[0][9];
    checks++;
    if (got !== 8'sd2) begin errors++; $display("FAIL rstmid_vx9: got %0d expected 2", got); end
    got = nodes_out[0][0];
    checks++;
    if (got !== 8'sd2) begin errors++; $display("FAIL rstmid_px0: got %0d expected 2", got); end
    got = nodes_out[1][5];
    checks++;
    if (got !== 8'sd1) begin errors++; $display("FAIL rstmid_py5: got %0d expected 1", got); end
    checks++;
    if (uv_count !== 1) begin errors++; $display("FAIL rstmid_uv_after: got %0d expected 1", uv_count); end
    $display("reset_mid: frame abandoned, next frame committed");
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] got;
    uv_count = 0; ce_count = 0;
    set_forces(4, 0);
    drive_beats(N, 1, 1'b1);
    checks++;
    if (update_valid !== 1'b0) begin errors++; $display("FAIL b2b_lat1: got %b expected 0", update_valid); end
    step();
    checks++;
    if (update_valid !== 1'b1) begin errors++; $display("FAIL b2b_lat2: got %b expected 1", update_valid); end
    got = velocities_out[0][3];
    checks++;
    if (got !== 8'sd4) begin errors++; $display("FAIL b2b_vx3: got %0d expected 4", got); end
    got = nodes_out[0][3];
    checks++;
    if (got !== 8'sd4) begin errors++; $display("FAIL b2b_px3: got %0d expected 4", got); end
    got = nodes_out[1][3];
    checks++;
    if (got !== 8'sd1) begin errors++; $display("FAIL b2b_py3: got %0d expected 1", got); end
    set_forces(-4, 0);
    drive_beats(N, 1, 1'b1);
    step();
    step();
    got = velocities_out[0][9];
    checks++;
    if (got !== 8'sd2) begin errors++; $display("FAIL b2b2_vx9: got %0d expected 2", got); end
    got = nodes_out[0][9];
    checks++;
    if (got !== 8'sd5) begin errors++; $display("FAIL b2b2_px9: got %0d expected 5", got); end
    checks++;
    if (uv_count !== 2) begin errors++; $display("FAIL b2b_uv: got %0d expected 2", uv_count); end
    checks++;
    if (ce_count !== 0) begin errors++; $display("FAIL b2b_ce: got %0d expected 0", ce_count); end
    $display("back_to_back: two frames committed");
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_saturation();
    test_arith_shift();
    test_short_frame();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (both_seen !== 1'b0) begin errors++; $display("FAIL uv_ce_overlap: got %b expected 0", both_seen); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/node_integrator.md
NODE_INTEGRATOR -- requirements
Module: node_integrator

Interface
REQ-001 Parameter NUM_NODES, default 10: number of nodes per frame.
REQ-002 Parameter POSITION_SIZE, default 8: signed position width.
REQ-003 Parameter VELOCITY_SIZE, default 8: signed velocity width.
REQ-004 Parameter FORCE_SIZE, default 8: signed force width.
REQ-005 Parameter CONSTANT_SIZE, default 4: unsigned dt_shift width.
REQ-006 Port clk_in, input, 1: single clock; all logic SHALL run on its rising edge.
REQ-007 Port rst_in, input, 1: reset, asynchronous and active-low.
REQ-008 Port init_valid, input, 1: load initial state, sampled in IDLE only.
REQ-009 Port init_nodes, input, [1:0][NUM_NODES] x POSITION_SIZE signed: initial positions, index 0 = x, index 1 = y.
REQ-010 Port dt_shift, input, CONSTANT_SIZE: time-step shift, sampled on the first force beat of each frame.
REQ-011 Port force_x_in / force_y_in, input, FORCE_SIZE signed each: per-node force beat.
REQ-012 Port force_in_valid, input, 1: force beat valid; beats arrive in node order 0..NUM_NODES-1 with no backpressure.
REQ-013 Port frame_done_in, input, 1: single-cycle end-of-frame strobe from the force producer.
REQ-014 Port nodes_out, output, [1:0][NUM_NODES] x POSITION_SIZE signed: committed positions.
REQ-015 Port velocities_out, output, [1:0][NUM_NODES] x VELOCITY_SIZE signed: committed velocities.
REQ-016 Port update_valid, output, 1: one-cycle pulse when a frame commits.
REQ-017 Port count_error, output, 1: one-cycle pulse on short frame or overrun.

Function
REQ-018 The FSM SHALL have states IDLE, ACCUM, FULL and COMMIT.
REQ-019 IDLE with init_valid=1 SHALL load positions and shadow positions from init_nodes and zero all velocities, with no update_valid pulse.
REQ-020 IDLE with force_in_valid=1 SHALL latch dt_shift, process the beat as node 0 and enter ACCUM; a simultaneous init_valid SHALL be ignored.
REQ-021 For each accepted beat k, the block SHALL compute v' = sat(v[k] + (f >>> dt_shift)) and p' = sat(p[k] + (v' >>> dt_shift)) per axis, using arithmetic shifts.
REQ-022 v' and p' SHALL be written to shadow arrays one cycle after the beat is accepted.
REQ-023 Saturation SHALL clamp to the signed range of the destination width, e.g. [-128,127] for width 8.
REQ-024 Sums SHALL be computed at destination width + 1 before clamping.
REQ-025 The beat counter SHALL be $clog2(NUM_NODES)+1 bits wide.
REQ-026 After beat NUM_NODES-1 the FSM SHALL enter FULL.
REQ-027 In FULL, any further force_in_valid beat SHALL be dropped and SHALL pulse count_error (overrun), once per dropped beat.
REQ-028 frame_done_in in FULL SHALL enter COMMIT.
REQ-029 COMMIT SHALL copy the shadow arrays to nodes_out and velocities_out atomically, pulse update_valid for exactly one cycle, and return to IDLE.
REQ-030 frame_done_in in ACCUM (short frame) SHALL discard the shadow arrays (restore them from the committed arrays), pulse count_error and return to IDLE.
REQ-031 force_in_valid and frame_done_in in the same cycle SHALL process the beat first, then evaluate frame_done_in against the updated count.
REQ-032 Outputs SHALL change only in COMMIT or on an IDLE init load.
REQ-033 Latency from frame_done_in (frame complete) to update_valid SHALL be 2 cycles.
REQ-034 update_valid and count_error SHALL never assert in the same cycle.

Reset
REQ-035 rst_in low SHALL immediately force IDLE and clear nodes_out, velocities_out, the shadow arrays, the beat counter, update_valid and count_error to 0.
REQ-036 Reset asserted mid-frame SHALL abandon the frame with no update_valid pulse.

Structure
REQ-037 The state enum and the saturating-add width rule SHALL live in a shared package, physics_pkg.
REQ-038 The per-axis velocity/position update SHALL be a single combinational sub-module, axis_integrate, instantiated twice (x and y).

Verification
REQ-039 Scenario: init all zero, dt_shift=0, force_x beats 1..10, force_y=-1, then frame_done_in -> velocities_out x[k]=k+1, y[k]=-1; nodes_out x[k]=k+1, y[k]=-1; update_valid pulses once.
REQ-040 Scenario: v_x[0]=120 after the prior frame, force_x=20 -> v_x[0]=127; at position 127, positive velocity -> position held at 127.
REQ-041 Scenario: dt_shift=2, force_x=-7 -> velocity -2 (arithmetic shift), position -1.
REQ-042 Scenario: 5 beats then frame_done_in -> count_error pulse, outputs unchanged; the next full frame integrates from the pre-error state.
REQ-043 Scenario: 12 beats then frame_done_in -> two count_error pulses, followed by a normal commit of the first 10 beats.
REQ-044 Scenario: rst_in low after beat 3 -> all outputs 0 and no update_valid; after reset release a full frame commits normally.
